divider_datapath: RTL

//  Datapath for the long-division unit. Holds the divisor, remainder, quotient and shift count.

---
 rtl/divider_datapath.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/divider_datapath.sv
// -----------------------------------------------------------------------------
// divider_datapath
//
// Register datapath for a restoring long-division unit. It holds the
// (normalised) divisor, the running remainder, the quotient being built and a
// shift count. It executes the init / left / right / sub micro-ops issued by
// the division controller. It returns the four status flags the controller
// branches on.
//
// Division sequence driven by the controller:
//   init                       load operands
//   left  x k                  normalise the divisor until its MSB is set
//   right x (k+1)              one quotient bit per step; sub asserted
//                              whenever divisor <= remainder
//
// Ports
//   clk                  in   1      rising-edge clock
//   reset_n              in   1      synchronous active-low reset
//   dividend             in   WIDTH  operand, sampled only on init
//   divisor              in   WIDTH  operand, sampled only on init
//   init                 in   1      load operands, clear quotient and count
//   left                 in   1      divisor <<1, count +1
//   right                in   1      quotient shift, divisor >>1, count -1
//   sub                  in   1      qualifies right: subtract, shift in a 1
//   quotient             out  WIDTH  quotient register
//   remainder            out  WIDTH  remainder register
//   divisor_is_zero      out  1      divisor register == 0
//   divisor_msb          out  1      divisor register MSB
//   cnt_is_zero          out  1      count == 0
//   dvsr_less_than_dvnd  out  1      divisor register <= remainder (unsigned)
// -----------------------------------------------------------------------------
module divider_datapath #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             init,
  input  logic             left,
  input  logic             right,
  input  logic             sub,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divisor_is_zero,
  output logic             divisor_msb,
  output logic             cnt_is_zero,
  output logic             dvsr_less_than_dvnd
);

  // Architectural state.
  logic [WIDTH-1:0] divisor_reg, divisor_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [CW-1:0]    count_reg, count_next;

  // Shift networks, built bit by bit so the fill values are explicit.
  logic [WIDTH-1:0] divisor_shl;   // divisor_reg << 1
  logic [WIDTH-1:0] divisor_shr;   // divisor_reg >> 1
  logic [WIDTH-1:0] quotient_shl;  // {quotient_reg[WIDTH-2:0], sub}

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
        assign divisor_shl[gi]  = 1'b0;
        assign quotient_shl[gi] = sub;
      end else begin : g_upper
        assign divisor_shl[gi]  = divisor_reg[gi-1];
        assign quotient_shl[gi] = quotient_reg[gi-1];
      end

      if (gi == WIDTH-1) begin : g_msb
        assign divisor_shr[gi] = 1'b0;
      end else begin : g_lower
        assign divisor_shr[gi] = divisor_reg[gi+1];
      end
    end
  endgenerate

  // Status flags come only from registers, so the controller never sees a
  // combinational path from its own micro-op outputs back to its inputs.
  assign divisor_is_zero     = (divisor_reg == '0);
  assign divisor_msb         = divisor_reg[WIDTH-1];
  assign cnt_is_zero         = (count_reg == '0);
  assign dvsr_less_than_dvnd = (divisor_reg <= rem_reg);

  assign quotient  = quotient_reg;
  assign remainder = rem_reg;

  // Micro-op decode. Priority is init > left > right; sub only matters when
  // right is the op being executed.
  always_comb begin
    divisor_next  = divisor_reg;
    rem_next      = rem_reg;
    quotient_next = quotient_reg;
    count_next    = count_reg;

    if (init) begin
      divisor_next  = divisor;
      rem_next      = dividend;
      quotient_next = '0;
      count_next    = '0;
    end else if (left) begin
      // Stop normalising once the MSB is set. A zero divisor would never
      // set it. Refusing the shift in both cases keeps count <= WIDTH-1.
      // It also makes a divide-by-zero sequence harmless.
      if (!divisor_msb && !divisor_is_zero) begin
        divisor_next = divisor_shl;
        count_next   = count_reg + CW'(1);
      end
    end else if (right) begin
      divisor_next  = divisor_shr;
      quotient_next = quotient_shl;
      if (sub) begin
        rem_next = rem_reg - divisor_reg;
      end
      // The final iteration is issued with count already at zero. Hold the
      // count there rather than wrap.
      if (!cnt_is_zero) begin
        count_next = count_reg - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      divisor_reg  <= '0;
      rem_reg      <= '0;
      quotient_reg <= '0;
      count_reg    <= '0;
    end else begin
      divisor_reg  <= divisor_next;
      rem_reg      <= rem_next;
      quotient_reg <= quotient_next;
      count_reg    <= count_next;
    end
  end

endmodule
